// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file's single write port: pipeline results take priority,
// long-latency results queue in a small FIFO, and a starvation guard stalls the pipeline so they drain.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        pipe_stall,
  output logic [4:0]  wb_rd,
  output logic [31:0] rddata,
  output logic        we
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;

  logic fifo_empty;
  logic pipe_sel;
  logic lu_live;
  logic pop;
  logic bypass;
  logic push;
  logic blocked;
  logic starve_hit;

  // Ready comes from the registered count only, so a pop at full never frees a slot the same cycle.
  assign lu_ready   = !rst && (count != CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign pipe_sel   = pipe_we && (pipe_rd != '0);
  assign lu_live    = lu_valid && lu_ready && (lu_rd != '0);
  assign pop        = !pipe_sel && !fifo_empty;
  assign bypass     = !pipe_sel && fifo_empty && lu_live;
  assign push       = lu_live && !bypass;
  assign blocked    = pipe_sel && !fifo_empty;
  assign starve_hit = blocked && (starve_cnt == SC_W'(STARVE_LIMIT - 1));

  // NOTE: the FIFO storage is deliberately not reset; count and pointers alone define which entries
  // are valid, so clearing them on reset discards stale data without a wide reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lu_rd, data: lu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      we         <= 1'b0;
      wb_rd      <= '0;
      rddata     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop || fifo_empty || starve_hit) starve_cnt <= '0;
      else if (blocked)                    starve_cnt <= starve_cnt + 1'b1;

      pipe_stall <= starve_hit;
      we         <= pipe_sel || pop || bypass;

      // Address/data hold when nothing is selected.
      if (pipe_sel) begin
        wb_rd  <= pipe_rd;
        rddata <= pipe_data;
      end else if (pop) begin
        wb_rd  <= mem[rd_ptr].rd;
        rddata <= mem[rd_ptr].data;
      end else if (bypass) begin
        wb_rd  <= lu_rd;
        rddata <= lu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model predicts each register-file
// write into a scoreboard; a monitor pops and compares whenever the DUT asserts we.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        pipe_stall;
  logic [4:0]  wb_rd;
  logic [31:0] rddata;
  logic        we;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t sb[$];        // expected writes, in order
  wr_t mq[$];        // model of buffered long-latency results
  int  starve_m = 0; // consecutive cycles the model saw the queue blocked by the pipe
  bit  stall_m  = 0; // model's expected pipe_stall for the coming cycle
  bit  exp_we   = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .pipe_stall(pipe_stall), .wb_rd(wb_rd), .rddata(rddata), .we(we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check status outputs, advance the model, check write enable.
  task automatic cycle(input bit r, input bit pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bit ready_m, pipe_win, hs, nonempty, byp;
    @(negedge clk);
    rst = r; pipe_we = pwe; pipe_rd = prd; pipe_data = pdata;
    lu_valid = lv; lu_rd = lrd; lu_data = ldata;
    #1;
    ready_m = !r && (mq.size() < DEPTH);
    check("lu_ready", 64'(lu_ready), 64'(ready_m));
    check("pipe_stall", 64'(pipe_stall), 64'(stall_m));
    if (r) begin
      mq.delete();
      starve_m = 0;
      stall_m  = 0;
      exp_we   = 0;
    end else begin
      pipe_win = pwe && (prd != 0);
      hs       = lv && ready_m;
      nonempty = mq.size() > 0;
      byp      = 0;
      stall_m  = 0;
      if (pipe_win) begin
        sb.push_back('{prd, pdata});
        if (nonempty) begin
          starve_m++;
          if (starve_m == STARVE_LIMIT) begin
            stall_m  = 1;
            starve_m = 0;
          end
        end
      end else if (nonempty) begin
        sb.push_back(mq.pop_front());
        starve_m = 0;
      end else if (hs && lrd != 0) begin
        sb.push_back('{lrd, ldata});
        byp = 1;
      end
      if (hs && lrd != 0 && !byp) mq.push_back('{lrd, ldata});
      exp_we = pipe_win || nonempty || byp;
    end
    @(posedge clk);
    #1;
    check("we", 64'(we), 64'(exp_we));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every presented write must be the next expected one and never target x0.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (wb_rd == 0) check("we_x0", 64'(wb_rd), 64'd1);
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(wb_rd), 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("rddata", 64'(rddata), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1; pipe_we = 0; pipe_rd = 0; pipe_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    @(posedge clk);

    // Reset held with an offered lu result, then release.
    cycle(1, 0, 0, 0, 1, 3, 32'h1);
    cycle(1, 0, 0, 0, 1, 3, 32'h1);
    check("wb_rd_reset", 64'(wb_rd), 64'd0);
    check("rddata_reset", 64'(rddata), 64'd0);
    idle(1);

    // Pipeline only, including the x0 idle case.
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 1, 0, 32'h55555555, 0, 0, 0);
    idle(1);

    // Bypass straight to the write port with the FIFO empty.
    cycle(0, 0, 0, 0, 1, 7, 32'h12345678);
    cycle(0, 0, 0, 0, 1, 0, 32'hBAD0BAD0); // handshake to x0 is dropped
    idle(1);

    // Contention: pipe busy every cycle unless stalled; x1..x4 queue up and drain on stall pulses.
    for (int i = 1; i <= 4; i++)
      cycle(0, 1, 5'd20, 32'hA000_0000 + i, 1, 5'(i), 32'hC000_0000 + i);
    cycle(0, 1, 5'd21, 32'hA100_0000, 1, 5'd6, 32'hEEEE_EEEE); // full: ignored
    for (int i = 0; i < 45; i++)
      cycle(0, !stall_m, 5'd22, 32'hA200_0000 + i, 0, 0, 0);
    idle(2);

    // Full FIFO, pipe idle, lu offering continuously: ready stays low the pop cycle, order kept.
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, 5'd23, 32'hB000_0000 + i, 1, 5'(10 + i), 32'hD000_0000 + i);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 0, 0, 1, 5'(16 + i), 32'hD100_0000 + i);
    idle(6);

    // Reset with three entries queued; stale entries must never be written.
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 5'd24, 32'hE000_0000 + i, 1, 5'(25 + i), 32'hF000_0000 + i);
    cycle(1, 1, 5'd24, 32'hE100_0000, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 9, 32'h9999_0009);
    idle(2);

    // Randomized traffic; the pipe mostly honours stall but occasionally violates it.
    for (int i = 0; i < 3000; i++) begin
      bit pwe, lv, r;
      logic [4:0] prd, lrd;
      pwe = stall_m ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      lv  = $urandom_range(0, 1);
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r   = ($urandom_range(0, 299) == 0);
      cycle(r, pwe, prd, $urandom, lv, lrd, $urandom);
    end
    idle(DEPTH + 4);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
